// File: rtl/stage_id_opr.sv
// stage_id_opr: operand-resolve stage with priority forwarding, load-use stall and registered valid/ready output
module stage_id_opr #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int NFWD   = 2,
    parameter int CTRL_W = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic                     in_rs1_en,
    input  logic                     in_rs2_en,
    input  logic [REG_AW-1:0]        in_rs1,
    input  logic [REG_AW-1:0]        in_rs2,
    input  logic [XLEN-1:0]          in_imm,
    input  logic [REG_AW-1:0]        in_rd,
    input  logic                     in_wreg,
    input  logic [CTRL_W-1:0]        in_ctrl,
    output logic [REG_AW-1:0]        rf_raddr1,
    output logic [REG_AW-1:0]        rf_raddr2,
    input  logic [XLEN-1:0]          rf_rdata1,
    input  logic [XLEN-1:0]          rf_rdata2,
    input  logic [NFWD-1:0]          fwd_wreg,
    input  logic [NFWD*REG_AW-1:0]   fwd_wd,
    input  logic [NFWD*XLEN-1:0]     fwd_wdata,
    input  logic [NFWD-1:0]          fwd_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_op1,
    output logic [XLEN-1:0]          out_op2,
    output logic [REG_AW-1:0]        out_rd,
    output logic                     out_wreg,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic                     stall_o,
    output logic [15:0]              stall_cnt
);

    logic [XLEN-1:0] op1, op2, fv1, fv2;
    logic            hit1, hit2, dn1, dn2, blk1, blk2, hazard, adv;

    // Resolve operands; scanning oldest to youngest lets the youngest match win
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        dn1  = 1'b1;
        dn2  = 1'b1;
        fv1  = '0;
        fv2  = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_wreg[i] && fwd_wd[i*REG_AW +: REG_AW] == in_rs1) begin
                hit1 = 1'b1;
                dn1  = fwd_done[i];
                fv1  = fwd_wdata[i*XLEN +: XLEN];
            end
            if (fwd_wreg[i] && fwd_wd[i*REG_AW +: REG_AW] == in_rs2) begin
                hit2 = 1'b1;
                dn2  = fwd_done[i];
                fv2  = fwd_wdata[i*XLEN +: XLEN];
            end
        end
        op1  = !in_rs1_en ? in_imm : (in_rs1 == '0) ? '0 : hit1 ? fv1 : rf_rdata1;
        op2  = !in_rs2_en ? in_imm : (in_rs2 == '0) ? '0 : hit2 ? fv2 : rf_rdata2;
        blk1 = in_rs1_en && (in_rs1 != '0) && hit1 && !dn1;
        blk2 = in_rs2_en && (in_rs2 != '0) && hit2 && !dn2;
    end

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;
    assign hazard    = in_valid && (blk1 || blk2);
    assign stall_o   = hazard && rdy && !flush;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = rdy && !flush && !hazard && adv;

    // Output register: pause freezes all state, flush kills, accept loads, otherwise drain to a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_wreg  <= 1'b0;
            out_ctrl  <= '0;
            stall_cnt <= '0;
        end else if (rdy) begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (in_valid && in_ready) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                out_op1   <= op1;
                out_op2   <= op2;
                out_rd    <= in_rd;
                out_wreg  <= in_wreg;
                out_ctrl  <= in_ctrl;
            end else if (adv) begin
                out_valid <= 1'b0;
            end
            if (stall_o && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_stage_id_opr.sv
// tb_stage_id_opr: directed self-checking bench for stage_id_opr
module tb_stage_id_opr;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_imm, rf_rdata1, rf_rdata2;
    logic        in_rs1_en, in_rs2_en, in_wreg;
    logic [4:0]  in_rs1, in_rs2, in_rd, rf_raddr1, rf_raddr2;
    logic [16:0] in_ctrl;
    logic [1:0]  fwd_wreg, fwd_done;
    logic [9:0]  fwd_wd;
    logic [63:0] fwd_wdata;
    logic        out_valid, out_ready, out_wreg, stall_o;
    logic [31:0] out_pc, out_op1, out_op2;
    logic [4:0]  out_rd;
    logic [16:0] out_ctrl;
    logic [15:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    stage_id_opr dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_rd(in_rd), .in_wreg(in_wreg), .in_ctrl(in_ctrl),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata), .fwd_done(fwd_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op1(out_op1),
        .out_op2(out_op2), .out_rd(out_rd), .out_wreg(out_wreg), .out_ctrl(out_ctrl),
        .stall_o(stall_o), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit   [6:0]  or_t  = 7'b1111001;
    bit   [6:0]  ir_t  = 7'b1111001;
    bit   [6:0]  v_t   = 7'b0111111;
    logic [31:0] pc_t [7] = '{32'h400, 32'h400, 32'h400, 32'h404, 32'h408, 32'h40C, 32'h40C};

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h50; in_rs1_en = 1'b1; in_rs2_en = 1'b1;
        in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = 32'h0; in_rd = 5'd4; in_wreg = 1'b1; in_ctrl = 17'h1;
        rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
        fwd_wreg = 2'b00; fwd_wd = '0; fwd_wdata = '0; fwd_done = 2'b11;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_pc", out_pc, 0);
        check("rst_op1", out_op1, 0);
        check("rst_ctrl", out_ctrl, 0);
        check("rst_cnt", stall_cnt, 0);
        rst = 1'b0;

        in_pc = 32'h100; in_rs1 = 5'd5; in_rs2 = 5'd3; rf_rdata1 = 32'h55; rf_rdata2 = 32'h33;
        in_rd = 5'd9; in_ctrl = 17'h1ABCD;
        fwd_wreg = 2'b11; fwd_wd = {5'd5, 5'd5}; fwd_wdata = {32'hBBBB, 32'hAAAA}; fwd_done = 2'b11;
        #1;
        check("fwd_in_ready", in_ready, 1);
        check("rf_raddr1", rf_raddr1, 5);
        tick();
        check("fwd_valid", out_valid, 1);
        check("fwd_op1_youngest", out_op1, 32'hAAAA);
        check("fwd_op2_rf", out_op2, 32'h33);
        check("fwd_pc", out_pc, 32'h100);
        check("fwd_rd", out_rd, 9);
        check("fwd_wreg", out_wreg, 1);
        check("fwd_ctrl", out_ctrl, 17'h1ABCD);
        in_pc = 32'h104; in_rs1 = 5'd0; fwd_wd = {5'd0, 5'd0};
        tick();
        check("x0_op1", out_op1, 0);
        check("x0_pc", out_pc, 32'h104);

        in_pc = 32'h108; in_rs1_en = 1'b0; in_imm = 32'h77; in_rs2 = 5'd7;
        fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd7}; fwd_wdata = {32'h0, 32'h1234}; fwd_done = 2'b00;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("lu_in_ready", in_ready, 0);
            check("lu_stall", stall_o, 1);
            tick();
            check("lu_bubble", out_valid, 0);
        end
        fwd_wreg = 2'b10; fwd_wd = {5'd7, 5'd0}; fwd_wdata = {32'h1234, 32'h0}; fwd_done = 2'b10;
        #1;
        check("lu_resolve_ready", in_ready, 1);
        check("lu_resolve_stall", stall_o, 0);
        tick();
        check("lu_valid", out_valid, 1);
        check("lu_op2", out_op2, 32'h1234);
        check("lu_op1_imm", out_op1, 32'h77);
        check("lu_cnt", stall_cnt, 2);

        fwd_wreg = 2'b00; in_rs2_en = 1'b0;
        begin
            int idx = 0;
            for (int c = 0; c < 7; c++) begin
                logic fire;
                in_valid  = (idx < 4);
                in_pc     = 32'h400 + 32'(idx) * 4;
                in_imm    = in_pc;
                out_ready = or_t[c];
                #1;
                check("bp_in_ready", in_ready, ir_t[c]);
                fire = in_valid && in_ready;
                tick();
                if (fire) idx++;
                check("bp_valid", out_valid, v_t[c]);
                if (v_t[c]) begin
                    check("bp_pc", out_pc, pc_t[c]);
                    check("bp_op1", out_op1, pc_t[c]);
                end
            end
            check("bp_count", idx, 4);
        end

        out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h200;
        tick();
        check("fl_pre_valid", out_valid, 1);
        in_pc = 32'h204; flush = 1'b1;
        #1;
        check("fl_in_ready", in_ready, 0);
        tick();
        check("fl_valid", out_valid, 0);
        flush = 1'b0;

        in_pc = 32'h300; in_imm = 32'h300;
        tick();
        check("pa_pre_pc", out_pc, 32'h300);
        rdy = 1'b0; in_pc = 32'h304; in_rs2_en = 1'b1; in_rs2 = 5'd7;
        fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd7}; fwd_done = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("pa_in_ready", in_ready, 0);
            check("pa_stall", stall_o, 0);
            tick();
            check("pa_valid", out_valid, 1);
            check("pa_pc", out_pc, 32'h300);
            check("pa_cnt", stall_cnt, 2);
        end
        rdy = 1'b1; fwd_wreg = 2'b00; in_rs2_en = 1'b0; in_imm = 32'hFFFFF800;
        tick();
        check("imm_op2", out_op2, 32'hFFFFF800);
        check("imm_pc", out_pc, 32'h304);

        in_pc = 32'h308; in_rs2_en = 1'b1; fwd_wreg = 2'b01;
        tick();
        check("rs_cnt3", stall_cnt, 3);
        check("rs_bubble", out_valid, 0);
        rst = 1'b1;
        tick();
        check("rs_valid", out_valid, 0);
        check("rs_cnt0", stall_cnt, 0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
